// File: rtl/cpu_run_ctrl.sv
// Run/step/breakpoint sequencer for the CPU core: produces a prescaled clock enable and
// stops the core on request, on a retired step, on core HALT or on a PC breakpoint.
// Optional feature macro: CPU_BREAKPOINT_EN (breakpoint compare, bp_mask and BREAK state).
module cpu_run_ctrl #(
  parameter int unsigned DIV_W = 16,
  parameter int unsigned PC_W  = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [DIV_W-1:0] prescale,
  input  logic             run_req,
  input  logic             step_req,
  input  logic             halt_req,
  input  logic             bp_valid,
  input  logic [PC_W-1:0]  bp_addr,
  input  logic [PC_W-1:0]  cpu_pc,
  input  logic             cpu_retired,
  input  logic             cpu_halted,
  output logic             cpu_ce,
  output logic [1:0]       state,
  output logic             bp_hit,
  output logic             step_done
);

  typedef enum logic [1:0] {
    StHalt  = 2'd0,
    StRun   = 2'd1,
    StStep  = 2'd2,
    StBreak = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             step_done_q, step_done_d;
  logic             active, tick, bp_stop, retire_ce, entering;

  assign active    = (state_q == StRun) || (state_q == StStep);
  assign tick      = active && (cnt_q == '0);
  assign cpu_ce    = tick && !bp_stop;
  assign retire_ce = cpu_ce && cpu_retired;

  always_comb begin
    state_d     = state_q;
    step_done_d = 1'b0;
    case (state_q)
      StHalt: begin
        if (step_req) begin
          state_d = StStep;
        end else if (run_req) begin
          state_d = StRun;
        end
      end
      StRun: begin
        if (halt_req) begin
          state_d = StHalt;
        end else if (tick && bp_stop) begin
          state_d = StBreak;
        end else if (cpu_ce && cpu_halted) begin
          state_d = StHalt;
        end
      end
      StStep: begin
        if (halt_req) begin
          state_d = StHalt;
        end else if (retire_ce) begin
          state_d     = StHalt;
          step_done_d = 1'b1;
        end
      end
      StBreak: begin
        if (halt_req) begin
          state_d = StHalt;
        end else if (step_req) begin
          state_d = StStep;
        end else if (run_req) begin
          state_d = StRun;
        end
      end
      default: state_d = StHalt;
    endcase
  end

  // Entering RUN/STEP zeroes the counter so the first enable lands on the next cycle.
  assign entering = (state_d != state_q) && ((state_d == StRun) || (state_d == StStep));

  always_comb begin
    cnt_d = cnt_q;
    if (entering) begin
      cnt_d = '0;
    end else if (tick) begin
      cnt_d = prescale;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - DIV_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StHalt;
      cnt_q       <= '0;
      step_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      step_done_q <= step_done_d;
    end
  end

`ifdef CPU_BREAKPOINT_EN
  logic bp_mask_q, bp_mask_d, bp_hit_q;

  assign bp_stop = (state_q == StRun) && bp_valid && (cpu_pc == bp_addr) && !bp_mask_q;

  // The mask lets a resume execute the instruction at the breakpoint PC once.
  always_comb begin
    bp_mask_d = bp_mask_q;
    if (state_d == StHalt) begin
      bp_mask_d = 1'b0;
    end else if ((state_q == StBreak) && (state_d != StBreak)) begin
      bp_mask_d = 1'b1;
    end else if (retire_ce) begin
      bp_mask_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bp_mask_q <= 1'b0;
      bp_hit_q  <= 1'b0;
    end else begin
      bp_mask_q <= bp_mask_d;
      bp_hit_q  <= (state_d == StBreak);
    end
  end

  assign bp_hit = bp_hit_q;
`else
  logic unused_bp;
  assign unused_bp = ^{bp_valid, bp_addr};
  assign bp_stop   = 1'b0;
  assign bp_hit    = 1'b0;
`endif

  assign state     = state_q;
  assign step_done = step_done_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Bench for cpu_run_ctrl: directed scenarios plus random requests, checked against a
// time-scheduled reference model and a simple multi-cycle core model.
module tb_cpu_run_ctrl;

  localparam int DIV_W = 16;
  localparam int PC_W  = 16;
`ifdef CPU_BREAKPOINT_EN
  localparam bit BpEn = 1'b1;
`else
  localparam bit BpEn = 1'b0;
`endif
  localparam int MHalt = 0, MRun = 1, MStep = 2, MBreak = 3;

  logic             clk, reset_n;
  logic [DIV_W-1:0] prescale;
  logic             run_req, step_req, halt_req, bp_valid;
  logic [PC_W-1:0]  bp_addr, cpu_pc;
  logic             cpu_retired, cpu_halted;
  logic             cpu_ce, bp_hit, step_done;
  logic [1:0]       state;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: enables are scheduled by absolute cycle number.
  int     m_state, m_nstate;
  longint now, m_next_ce;
  bit     m_mask, m_step_done, m_ce, m_tick;

  // Core model: each instruction takes core_len enables; PC walks loop_lo..loop_hi.
  logic [PC_W-1:0] core_pc, loop_lo, loop_hi;
  int              core_k, core_len;
  bit              rand_len;

  logic [4:0] exp_v, act_v;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  cpu_run_ctrl #(.DIV_W(DIV_W), .PC_W(PC_W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .prescale   (prescale),
    .run_req    (run_req),
    .step_req   (step_req),
    .halt_req   (halt_req),
    .bp_valid   (bp_valid),
    .bp_addr    (bp_addr),
    .cpu_pc     (cpu_pc),
    .cpu_retired(cpu_retired),
    .cpu_halted (cpu_halted),
    .cpu_ce     (cpu_ce),
    .state      (state),
    .bp_hit     (bp_hit),
    .step_done  (step_done)
  );

  task automatic model_reset();
    m_state     = MHalt;
    m_mask      = 1'b0;
    m_step_done = 1'b0;
    m_next_ce   = 0;
  endtask

  // Drive core outputs, evaluate the model for this cycle, then settle.
  task automatic eval();
    bit bpstop;
    cpu_pc      = core_pc;
    cpu_retired = (core_k == core_len - 1);
    m_tick = ((m_state == MRun) || (m_state == MStep)) && (now == m_next_ce);
    bpstop = BpEn && (m_state == MRun) && bp_valid && (cpu_pc == bp_addr) && !m_mask;
    m_ce   = m_tick && !bpstop;
    m_nstate = m_state;
    case (m_state)
      MHalt:  if (step_req) m_nstate = MStep; else if (run_req) m_nstate = MRun;
      MRun:   if (halt_req) m_nstate = MHalt;
              else if (m_tick && bpstop) m_nstate = MBreak;
              else if (m_ce && cpu_halted) m_nstate = MHalt;
      MStep:  if (halt_req || (m_ce && cpu_retired)) m_nstate = MHalt;
      default: if (halt_req) m_nstate = MHalt;
               else if (step_req) m_nstate = MStep;
               else if (run_req) m_nstate = MRun;
    endcase
    exp_v = {m_ce, 2'(m_state), (m_state == MBreak), m_step_done};
    #1;
    act_v = {cpu_ce, state, bp_hit, step_done};
  endtask

  task automatic tick_clk();
    @(posedge clk);
    m_step_done = (m_state == MStep) && !halt_req && m_ce && cpu_retired;
    if (m_nstate == MHalt) m_mask = 1'b0;
    else if (m_state == MBreak && m_nstate != MBreak) m_mask = 1'b1;
    else if (m_ce && cpu_retired) m_mask = 1'b0;
    if (m_nstate != m_state && (m_nstate == MRun || m_nstate == MStep)) m_next_ce = now + 1;
    else if (m_tick) m_next_ce = now + longint'(prescale) + 1;
    m_state = m_nstate;
    now++;
    if (m_ce) begin
      if (core_k == core_len - 1) begin
        core_k  = 0;
        core_pc = (core_pc == loop_hi) ? loop_lo : core_pc + 16'd1;
        if (rand_len) core_len = int'($urandom_range(1, 3));
      end else begin
        core_k++;
      end
    end
    @(negedge clk);
    run_req  = 1'b0;
    step_req = 1'b0;
    halt_req = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    model_reset();
    @(negedge clk);
    #1;
    n_checks++; if (state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d required 0", state); end
    n_checks++; if (cpu_ce !== 1'b0) begin n_fail++; $display("FAIL reset_ce: got %b required 0", cpu_ce); end
    n_checks++; if (bp_hit !== 1'b0) begin n_fail++; $display("FAIL reset_bp_hit: got %b required 0", bp_hit); end
    n_checks++; if (step_done !== 1'b0) begin n_fail++; $display("FAIL reset_step_done: got %b required 0", step_done); end
    @(negedge clk);
    reset_n = 1'b1;
    eval();
    n_checks++; if (act_v !== exp_v) begin n_fail++; $display("FAIL reset_idle: ce/st/hit/done %b required %b", act_v, exp_v); end
    tick_clk();
  endtask

  task automatic test_run_prescale();
    prescale = 16'd3; bp_valid = 1'b0; cpu_halted = 1'b0; core_len = 1; core_k = 0;
    run_req = 1'b1;
    eval();
    n_checks++; if (act_v !== exp_v) begin n_fail++; $display("FAIL run_req_cycle: %b required %b", act_v, exp_v); end
    tick_clk();
    for (int i = 1; i <= 13; i++) begin
      eval();
      n_checks++; if (act_v !== exp_v) begin n_fail++; $display("FAIL run_model c%0d: %b required %b", i, act_v, exp_v); end
      n_checks++;
      if (cpu_ce !== (((i - 1) % 4) == 0) || state !== 2'd1) begin
        n_fail++; $display("FAIL run_period c%0d: ce=%b state=%0d required ce=%b state=1", i, cpu_ce, state, ((i - 1) % 4) == 0);
      end
      tick_clk();
    end
    halt_req = 1'b1;
    eval();
    n_checks++; if (act_v !== exp_v) begin n_fail++; $display("FAIL run_halt_req: %b required %b", act_v, exp_v); end
    tick_clk();
    for (int i = 0; i < 8; i++) begin
      eval();
      n_checks++;
      if (cpu_ce !== 1'b0 || state !== 2'd0) begin
        n_fail++; $display("FAIL run_after_halt c%0d: ce=%b state=%0d required ce=0 state=0", i, cpu_ce, state);
      end
      tick_clk();
    end
  endtask

  task automatic test_step();
    int ces, dones;
    ces = 0; dones = 0;
    prescale = 16'd0; core_len = 4; core_k = 0;
    step_req = 1'b1;
    eval();
    n_checks++; if (act_v !== exp_v) begin n_fail++; $display("FAIL step_req_cycle: %b required %b", act_v, exp_v); end
    tick_clk();
    for (int i = 0; i < 12; i++) begin
      eval();
      n_checks++; if (act_v !== exp_v) begin n_fail++; $display("FAIL step_model c%0d: %b required %b", i, act_v, exp_v); end
      if (cpu_ce === 1'b1) ces++;
      if (step_done === 1'b1) dones++;
      tick_clk();
    end
    n_checks++; if (ces != 4) begin n_fail++; $display("FAIL step_ce_count: got %0d required 4", ces); end
    n_checks++; if (dones != 1) begin n_fail++; $display("FAIL step_done_count: got %0d required 1", dones); end
    n_checks++; if (state !== 2'd0) begin n_fail++; $display("FAIL step_end_state: got %0d required 0", state); end
  endtask

  task automatic test_breakpoint();
    int breaks, ce_at_bp;
    bit resumed;
    logic prev_hit;
    breaks = 0; ce_at_bp = 0; resumed = 1'b0; prev_hit = 1'b0;
    prescale = 16'd0; core_len = 2; core_k = 0;
    loop_lo = 16'h014E; loop_hi = 16'h0153; core_pc = 16'h014C;
    bp_valid = 1'b1; bp_addr = 16'h0150;
    run_req = 1'b1;
    eval();
    tick_clk();
    for (int i = 0; i < 80 && breaks < 2; i++) begin
      if (m_state == MBreak && !resumed) begin
        run_req = 1'b1; resumed = 1'b1;
      end
      eval();
      n_checks++; if (act_v !== exp_v) begin n_fail++; $display("FAIL bp_model c%0d pc=%h: %b required %b", i, cpu_pc, act_v, exp_v); end
      if (cpu_ce === 1'b1 && cpu_pc == 16'h0150) ce_at_bp++;
      if (bp_hit === 1'b1 && prev_hit !== 1'b1) breaks++;
      prev_hit = bp_hit;
      tick_clk();
    end
    n_checks++;
    if (breaks != (BpEn ? 2 : 0)) begin
      n_fail++; $display("FAIL bp_break_count: got %0d required %0d", breaks, BpEn ? 2 : 0);
    end
    n_checks++; if (ce_at_bp == 0) begin n_fail++; $display("FAIL bp_ce_at_addr: got %0d required >0", ce_at_bp); end
  endtask

  task automatic test_halt_step_break();
    halt_req = 1'b1; step_req = 1'b1;
    eval();
    n_checks++; if (act_v !== exp_v) begin n_fail++; $display("FAIL hs_req_cycle: %b required %b", act_v, exp_v); end
    tick_clk();
    for (int i = 0; i < 3; i++) begin
      eval();
      n_checks++;
      if (state !== 2'd0 || step_done !== 1'b0 || cpu_ce !== 1'b0) begin
        n_fail++; $display("FAIL hs_after c%0d: state=%0d done=%b ce=%b required 0 0 0", i, state, step_done, cpu_ce);
      end
      tick_clk();
    end
  endtask

  task automatic test_cpu_halted();
    prescale = 16'd2; bp_valid = 1'b0; core_len = 1; core_k = 0; cpu_halted = 1'b0;
    run_req = 1'b1;
    eval();
    tick_clk();
    cpu_halted = 1'b1;
    eval();
    n_checks++; if (act_v !== exp_v) begin n_fail++; $display("FAIL halted_ce_cycle: %b required %b", act_v, exp_v); end
    tick_clk();
    cpu_halted = 1'b0;
    eval();
    n_checks++; if (state !== 2'd0) begin n_fail++; $display("FAIL halted_state: got %0d required 0", state); end
    n_checks++; if (act_v !== exp_v) begin n_fail++; $display("FAIL halted_model: %b required %b", act_v, exp_v); end
    tick_clk();
  endtask

  task automatic test_reset_mid_run();
    prescale = 16'd1; bp_valid = 1'b0; core_len = 3; core_k = 0;
    run_req = 1'b1;
    eval();
    tick_clk();
    for (int i = 0; i < 2; i++) begin
      eval();
      n_checks++; if (act_v !== exp_v) begin n_fail++; $display("FAIL mid_model c%0d: %b required %b", i, act_v, exp_v); end
      tick_clk();
    end
    eval();
    n_checks++; if (cpu_ce !== 1'b1) begin n_fail++; $display("FAIL mid_pre_ce: got %b required 1", cpu_ce); end
    #2 reset_n = 1'b0;
    #1;
    n_checks++; if (cpu_ce !== 1'b0) begin n_fail++; $display("FAIL mid_reset_ce: got %b required 0", cpu_ce); end
    n_checks++; if (state !== 2'd0) begin n_fail++; $display("FAIL mid_reset_state: got %0d required 0", state); end
    model_reset();
    core_k = 0;
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    run_req = 1'b0; step_req = 1'b0; halt_req = 1'b0;
    eval();
    n_checks++; if (act_v !== exp_v) begin n_fail++; $display("FAIL mid_after: %b required %b", act_v, exp_v); end
    tick_clk();
  endtask

  task automatic test_random();
    loop_lo = 16'h014C; loop_hi = 16'h0155; core_pc = 16'h014C; core_k = 0; core_len = 1;
    rand_len = 1'b1; bp_addr = 16'h0150; bp_valid = 1'b1; prescale = 16'd0;
    for (int i = 0; i < 2000; i++) begin
      run_req    = ($urandom_range(0, 15) == 0);
      step_req   = ($urandom_range(0, 19) == 0);
      halt_req   = ($urandom_range(0, 29) == 0);
      cpu_halted = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 63) == 0) prescale = 16'($urandom_range(0, 3));
      if ($urandom_range(0, 99) == 0) bp_valid = ~bp_valid;
      eval();
      n_checks++; if (act_v !== exp_v) begin n_fail++; $display("FAIL rand c%0d pc=%h: %b required %b", i, cpu_pc, act_v, exp_v); end
      tick_clk();
    end
    rand_len = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; prescale = '0; run_req = 1'b0; step_req = 1'b0; halt_req = 1'b0;
    bp_valid = 1'b0; bp_addr = '0; cpu_halted = 1'b0; rand_len = 1'b0;
    loop_lo = 16'h0100; loop_hi = 16'h01FF; core_pc = 16'h0100; core_k = 0; core_len = 1;
    cpu_pc = core_pc; cpu_retired = 1'b0; now = 0;
    model_reset();
    test_reset();
    test_run_prescale();
    test_step();
    test_breakpoint();
    test_halt_step_break();
    test_cpu_halted();
    test_reset_mid_run();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_run_ctrl.md
# cpu_run_ctrl

Run/step/breakpoint controller for the Game Boy CPU core on the FPGA board. Sits between the board clock domain and `main`: it replaces the free-running clock-divider bit with a single-clock-domain clock-enable (`cpu_ce`) and sequences the core through halted, free-running, single-instruction-step and breakpoint states. It watches the core's debug PC, instruction-retired and halted outputs to decide when to stop.

## Interface
- `DIV_W`, default 16: prescaler width. Sets the slowest selectable CPU rate.
- `PC_W`, default 16: PC and breakpoint address width.

Ports:
- `clk`  in  1: board clock; all logic on the rising edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `prescale`  in  DIV_W: reload value. `cpu_ce` fires once every `prescale`+1 cycles.
- `run_req`  in  1: one-cycle pulse requesting free run.
- `step_req`  in  1: one-cycle pulse requesting execution of exactly one instruction.
- `halt_req`  in  1: one-cycle pulse requesting a stop.
- `bp_valid`  in  1: breakpoint armed.
- `bp_addr`  in  PC_W: breakpoint PC.
- `cpu_pc`  in  PC_W: core's current PC (`dbg_pc`).
- `cpu_retired`  in  1: core's instruction-retired flag. Meaningful only in cycles with `cpu_ce`=1.
- `cpu_halted`  in  1: core has executed HALT/STOP.
- `cpu_ce`  out  1: clock enable to the core, one cycle wide.
- `state`  out  2: encoding is HALT=0, RUN=1, STEP=2, BREAK=3.
- `bp_hit`  out  1: high while in BREAK.
- `step_done`  out  1: one-cycle pulse when a step completes.

## Operation
- Reset values:
  - `state`=HALT
  - prescaler counter `cnt`=0
  - `bp_mask`=0
  - `cpu_ce`=0, `bp_hit`=0, `step_done`=0
- Request priority when pulses coincide: `halt_req` > `step_req` > `run_req`.
- `tick` = (`cnt`==0) and `state` is RUN or STEP.
  - When `tick` is high, `cnt` reloads with `prescale`. Otherwise it decrements.
  - On entry to RUN or STEP, `cnt` is loaded with 0.
- `cpu_ce` = `tick` and not `bp_stop`.
- `bp_stop` = `state`==RUN and `bp_valid` and `cpu_pc`==`bp_addr` and not `bp_mask`.
- HALT:
  - `step_req` → STEP.
  - `run_req` → RUN.
  - `halt_req` is ignored.
- RUN:
  - `halt_req` → HALT.
  - `tick`&`bp_stop` → BREAK. No `cpu_ce` is issued in that cycle.
  - `cpu_ce`&`cpu_halted` → HALT.
  - `step_req`/`run_req` are ignored.
- STEP:
  - `cpu_ce`&`cpu_retired` → HALT, with `step_done` pulsed on the next cycle.
  - `halt_req` → HALT, with no `step_done`.
  - Breakpoints are never checked in STEP.
- BREAK:
  - `step_req` → STEP.
  - `run_req` → RUN.
  - `halt_req` → HALT.
  - `bp_hit` is high only while in BREAK.
- `bp_mask`:
  - Set on any transition out of BREAK, so a resume does not re-break at the same PC.
  - Cleared on the first `cpu_ce`&`cpu_retired` after it was set, or on entry to HALT.
- A core that reports `cpu_halted` while in STEP still completes via `cpu_retired`; it does not stall the controller.

## Timing
- Requests sampled in cycle N change `state` at the end of N. They never gate `cpu_ce` within N.
- `cpu_ce` is asserted in the first cycle after entry to RUN/STEP. It then asserts every `prescale`+1 cycles. With `prescale`=0 it asserts every cycle.
- `prescale` is sampled only at reload. A change takes effect after the current period.
- `state`, `bp_hit`, `step_done` and `cnt` are registered. `cpu_ce` is a combinational decode of registered state and the PC compare.
- `reset_n` low mid-instruction forces HALT immediately. `cpu_ce` drops asynchronously with `state`.
- `cnt` wraps only via reload. It never underflows.

## Configuration
- `CPU_BREAKPOINT_EN` defined: the breakpoint compare, `bp_mask` and the BREAK state are built.
- `CPU_BREAKPOINT_EN` undefined:
  - `bp_stop` is tied to 0, so BREAK is unreachable.
  - `bp_hit` is tied to 0.
  - `bp_valid`/`bp_addr` are ignored.
  - The state encoding is unchanged.

## Test plan
- Reset, `prescale`=3, `run_req` pulse → `state`=1; `cpu_ce` high in cycles 1, 5, 9… after entry; `halt_req` → `state`=0, no further `cpu_ce`.
- HALT, `prescale`=0, `step_req`; core model retires on its 4th `cpu_ce` → exactly 4 `cpu_ce` pulses, then `state`=0 and a single `step_done` pulse.
- RUN, `prescale`=0, `bp_valid`=1, `bp_addr`=0x0150, `cpu_pc` reaching 0x0150 → no `cpu_ce` at 0x0150, `state`=3, `bp_hit`=1; then `run_req` → `cpu_ce` resumes at 0x0150 with no re-break; a later return to 0x0150 breaks again.
- `halt_req` and `step_req` pulsed in the same cycle while in BREAK → `state`=0, `step_done` stays 0.
- RUN with `cpu_halted`=1 on a `cpu_ce` cycle → `state`=0 next cycle; assert `reset_n`=0 mid-RUN → `cpu_ce`=0, `state`=0 immediately.
- Build without `CPU_BREAKPOINT_EN`: repeat the breakpoint scenario → `cpu_ce` continues through 0x0150, `bp_hit`=0 throughout.
